// File: rtl/regfile_dump_ctrl_if.sv
// Byte stream port of the register-file dump controller: data/valid/last from the
// controller, ready from the sink.
interface regfile_dump_ctrl_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] dump_data;
  logic              dump_valid;
  logic              dump_ready;
  logic              dump_last;

  modport master (
    output dump_data,
    output dump_valid,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_data,
    input  dump_valid,
    input  dump_last,
    output dump_ready
  );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// Walks the register file read port from address 0 to NUM_REGS-1 and streams one byte per
// register. Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum byte to every dump.
module regfile_dump_ctrl #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [ADDR_W-1:0]        read_addr_out,
  input  logic [DATA_W-1:0]        reg_data_in,
  regfile_dump_ctrl_if.master      dump,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StDone,
    StCsum
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StDone
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          addr_d  = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StFetch: begin
        // Only capture point: later register writes cannot disturb the byte in flight.
        data_d  = reg_data_in;
        valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        last_d  = 1'b0;
`else
        last_d  = (addr_q == LastAddr);
`endif
        state_d = StSend;
      end
      StSend: begin
        if (valid_q && dump.dump_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
`endif
          if (addr_q != LastAddr) begin
            addr_d  = addr_q + ADDR_W'(1);
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = StFetch;
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            // Checksum byte follows immediately; valid stays high.
            data_d  = csum_q ^ data_q;
            last_d  = 1'b1;
            state_d = StCsum;
`else
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = StDone;
`endif
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      StCsum: begin
        if (valid_q && dump.dump_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign read_addr_out   = addr_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_valid = valid_q;
  assign dump.dump_last  = last_q;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  assign busy = (state_q == StFetch) || (state_q == StSend) || (state_q == StCsum);
`else
  assign busy = (state_q == StFetch) || (state_q == StSend);
`endif
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with a behavioural 8x8 register file on its read port.
module tb_regfile_dump_ctrl;

  localparam int unsigned NREG = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] read_addr;
  logic [7:0] reg_data;
  logic       busy;
  logic       done;

  logic [7:0] regs  [NREG];
  logic [7:0] exp_b [NREG+1];
  int         exp_n;
  int         n_checks = 0;
  int         n_pass   = 0;

  regfile_dump_ctrl_if #(.DATA_W(8)) dif ();

  regfile_dump_ctrl #(
    .NUM_REGS(NREG),
    .ADDR_W  (3),
    .DATA_W  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .read_addr_out(read_addr),
    .reg_data_in  (reg_data),
    .dump         (dif),
    .busy         (busy),
    .done         (done)
  );

  assign reg_data = regs[read_addr];

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Fills the register file and builds the expected byte stream from it.
  task automatic load_regs(input logic [7:0] base, input logic [7:0] inc);
    logic [7:0] csum;
    csum = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      regs[i]  = base + 8'(i) * inc;
      exp_b[i] = regs[i];
      csum     = csum ^ regs[i];
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    exp_b[NREG] = csum;
    exp_n       = NREG + 1;
`else
    exp_n       = NREG;
`endif
  endtask

  // Entered at the first FETCH sample. Mode 0: ready high; 1: random stalls;
  // 2: stall on byte 3 while rewriting reg 3; 3: reset while byte 4 is held.
  task automatic run_dump(input int mode, input string tag);
    int         idx = 0;
    int         cyc = 0;
    int         hold = 0;
    int         stall;
    int         last_cyc;
    logic       rdy;
    logic       pv = 1'b0;
    logic       pr = 1'b1;
    logic [7:0] pd = 8'h00;
    logic       pl = 1'b0;
    last_cyc = 2 * NREG - 1 + (exp_n - NREG);
    stall = $urandom_range(0, 5);
    while (idx < exp_n && cyc < 200) begin
      rdy = 1'b1;
      if (mode == 1 && stall > 0) begin
        rdy = 1'b0;
        if (dif.dump_valid) stall--;
      end
      if (mode == 2 && idx == 3 && dif.dump_valid && hold < 3) begin
        rdy     = 1'b0;
        regs[3] = 8'hAA;
        hold++;
      end
      if (mode == 3 && idx == 4 && dif.dump_valid) begin
        check({tag, ":abort_addr"}, 32'(read_addr), 32'd4);
        dif.dump_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check({tag, ":abort_valid"}, 32'(dif.dump_valid), 32'd0);
        check({tag, ":abort_last"}, 32'(dif.dump_last), 32'd0);
        check({tag, ":abort_busy"}, 32'(busy), 32'd0);
        check({tag, ":abort_done"}, 32'(done), 32'd0);
        check({tag, ":abort_data"}, 32'(dif.dump_data), 32'd0);
        check({tag, ":abort_raddr"}, 32'(read_addr), 32'd0);
        return;
      end
      dif.dump_ready = rdy;
      if (pv && !pr) begin
        check({tag, ":stall_valid"}, 32'(dif.dump_valid), 32'(pv));
        check({tag, ":stall_data"}, 32'(dif.dump_data), 32'(pd));
        check({tag, ":stall_last"}, 32'(dif.dump_last), 32'(pl));
      end
      if (dif.dump_valid && rdy) begin
        check({tag, ":data"}, 32'(dif.dump_data), 32'(exp_b[idx]));
        check({tag, ":last"}, 32'(dif.dump_last), 32'(idx == exp_n - 1));
        check({tag, ":busy"}, 32'(busy), 32'd1);
        if (mode == 0 && idx == exp_n - 1) check({tag, ":last_cycle"}, cyc, last_cyc);
        idx++;
        stall = $urandom_range(0, 5);
      end
      pv = dif.dump_valid;
      pr = rdy;
      pd = dif.dump_data;
      pl = dif.dump_last;
      step();
      cyc++;
    end
    check({tag, ":byte_count"}, idx, exp_n);
    check({tag, ":done_pulse"}, 32'(done), 32'd1);
    check({tag, ":done_busy"}, 32'(busy), 32'd0);
    check({tag, ":done_valid"}, 32'(dif.dump_valid), 32'd0);
  endtask

  task automatic start_pulse(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, ":fetch_busy"}, 32'(busy), 32'd1);
    check({tag, ":fetch_valid"}, 32'(dif.dump_valid), 32'd0);
    check({tag, ":fetch_addr"}, 32'(read_addr), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    dif.dump_ready = 1'b0;
    load_regs(8'h11, 8'h11);
    step();
    step();
    check("rst_valid", 32'(dif.dump_valid), 32'd0);
    check("rst_last", 32'(dif.dump_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(dif.dump_data), 32'd0);
    check("rst_raddr", 32'(read_addr), 32'd0);

    // Ready high while idle must not produce anything.
    reset          = 1'b0;
    dif.dump_ready = 1'b1;
    step();
    step();
    check("idle_valid", 32'(dif.dump_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Bytes 11..88, ready held high.
    start_pulse("d11");
    run_dump(0, "d11");
    step();
    check("d11:after_done", 32'(done), 32'd0);
    check("d11:after_busy", 32'(busy), 32'd0);

    // Bytes 01..08.
    load_regs(8'h01, 8'h01);
    start_pulse("d01");
    run_dump(0, "d01");
    step();

    // Random backpressure.
    load_regs(8'h3C, 8'h17);
    start_pulse("bp");
    run_dump(1, "bp");
    step();

    // Reg 3 rewritten while its byte is held: old value streams now, new value next time.
    load_regs(8'h11, 8'h11);
    start_pulse("wr");
    run_dump(2, "wr");
    step();
    check("wr:reg3", 32'(regs[3]), 32'h0000_00AA);
    exp_b[3] = 8'hAA;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    exp_b[NREG] = exp_b[NREG] ^ 8'h44 ^ 8'hAA;
`endif
    start_pulse("wr2");
    run_dump(0, "wr2");
    step();

    // Reset while byte 4 is in SEND, then a clean restart from address 0.
    load_regs(8'h10, 8'h03);
    start_pulse("ab");
    run_dump(3, "ab");
    step();
    check("ab:no_done", 32'(done), 32'd0);
    check("ab:idle_busy", 32'(busy), 32'd0);
    start_pulse("ab2");
    run_dump(0, "ab2");
    step();

    // Start held high across a dump: exactly two dumps, the second right after DONE.
    load_regs(8'h11, 8'h11);
    start = 1'b1;
    step();
    check("hold:fetch_busy", 32'(busy), 32'd1);
    run_dump(0, "hold1");
    step();
    check("hold:idle_busy", 32'(busy), 32'd0);
    check("hold:idle_done", 32'(done), 32'd0);
    step();
    check("hold:restart_busy", 32'(busy), 32'd1);
    check("hold:restart_addr", 32'(read_addr), 32'd0);
    start = 1'b0;
    run_dump(0, "hold2");
    step();
    step();
    check("hold:no_third", 32'(busy), 32'd0);
    step();
    check("hold:still_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
